// File: rtl/os_pkg.sv
// -----------------------------------------------------------------------------
// os_pkg
// Shared definitions for the output-stationary column drain sequencer:
//   - os_state_e      : sequencer states (IDLE, LOAD, MAC, SNAP, SHIFT, FINAL)
//   - PE_CTL_*        : broadcast PE control encodings, packed {ready, rw, stream}
//   - drain_cnt_width : width of the drain index counter for a given chain depth
// -----------------------------------------------------------------------------
package os_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        MAC   = 3'd2,
        SNAP  = 3'd3,
        SHIFT = 3'd4,
        FINAL = 3'd5
    } os_state_e;

    // PE control words, bit order {ready, rw, stream}
    localparam logic [2:0] PE_CTL_CLEAR = 3'b000;
    localparam logic [2:0] PE_CTL_MAC   = 3'b110;
    localparam logic [2:0] PE_CTL_SNAP  = 3'b100;
    localparam logic [2:0] PE_CTL_SHIFT = 3'b111;
    localparam logic [2:0] PE_CTL_FINAL = 3'b000;

    // The drain index runs 0 .. 2*rows-1, so it needs clog2(2*rows) bits
    function automatic int drain_cnt_width(input int rows);
        return $clog2(2 * rows);
    endfunction

endpackage

// File: rtl/os_drain_fifo.sv
// -----------------------------------------------------------------------------
// os_drain_fifo
// First-word-fall-through FIFO holding drained results ({last, row, data}).
// The head entry is presented straight from the storage registers, so a word
// pushed at an edge is visible on w_pop_data right after that edge.
//
// Ports:
//   w_clk, w_rst_n : clock, asynchronous active-low reset
//   w_push         : write w_push_data (ignored when full)
//   w_push_data    : payload to store
//   w_pop          : consumer accepts the head entry (ignored when empty)
//   w_valid        : FIFO non-empty
//   w_pop_data     : head entry, forced to 0 while empty
//   w_count        : registered occupancy
// -----------------------------------------------------------------------------
module os_drain_fifo #(
    parameter  int WIDTH = 19,
    parameter  int DEPTH = 8,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             w_clk,
    input  logic             w_rst_n,
    input  logic             w_push,
    input  logic [WIDTH-1:0] w_push_data,
    input  logic             w_pop,
    output logic             w_valid,
    output logic [WIDTH-1:0] w_pop_data,
    output logic [CNT_W-1:0] w_count
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             push_ok;
    logic             pop_ok;

    assign push_ok = w_push && (count != FULL_CNT);
    assign pop_ok  = w_pop && (count != '0);

    // Storage array: no reset needed because the output is masked while empty
    always_ff @(posedge w_clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= w_push_data;
        end
    end

    // Pointers wrap at DEPTH so non-power-of-two depths work too; the count
    // is kept explicitly so full/empty never needs pointer comparison
    always_ff @(posedge w_clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + 1'b1;
            end
            count <= count + CNT_W'(push_ok) - CNT_W'(pop_ok);
        end
    end

    assign w_valid    = (count != '0);
    assign w_pop_data = (count != '0) ? mem[rd_ptr] : '0;
    assign w_count    = count;

endmodule

// File: rtl/os_col_drain.sv
// -----------------------------------------------------------------------------
// os_col_drain
// Sequencer and result collector for one column of output-stationary PEs.
// Walks the PE chain through LOAD, MAC, SNAP, SHIFT and FINAL, and captures
// the partial sums that leave the tail PE into a result FIFO, deepest row
// first and row 0 (flagged last) at the end.
//
// Optional feature: define OS_DRAIN_BUBBLE_CHECK_EN to enable the sticky chain
// error (nonzero/unknown tail during a bubble cycle, or push into a full FIFO).
// Without it w_err is tied to 0.
//
// Ports:
//   w_clk, w_rst_n      : clock, asynchronous active-low reset
//   w_start, w_k        : start a tile with w_k MAC cycles (sampled in IDLE)
//   w_busy, w_done      : tile in progress / one-cycle FINAL pulse
//   w_mac_en            : upstream may feed operands (MAC state)
//   w_pe_ready/rw/stream: broadcast PE controls
//   w_pe_fwd_head       : forward input of PE 0, always 0
//   w_pe_tail           : w_out of the last PE in the chain
//   w_res_*             : valid/ready result stream {data, row, last}
//   w_err               : sticky chain error
// -----------------------------------------------------------------------------
module os_col_drain
    import os_pkg::*;
#(
    parameter  int ROWS       = 4,
    parameter  int FWD_WIDTH  = 16,
    parameter  int K_WIDTH    = 8,
    parameter  int FIFO_DEPTH = 8,
    localparam int ROW_W      = $clog2(ROWS)
) (
    input  logic                 w_clk,
    input  logic                 w_rst_n,
    input  logic                 w_start,
    input  logic [K_WIDTH-1:0]   w_k,
    output logic                 w_busy,
    output logic                 w_done,
    output logic                 w_mac_en,
    output logic                 w_pe_ready,
    output logic                 w_pe_rw,
    output logic                 w_pe_stream,
    output logic [FWD_WIDTH-1:0] w_pe_fwd_head,
    input  logic [FWD_WIDTH-1:0] w_pe_tail,
    output logic                 w_res_valid,
    input  logic                 w_res_ready,
    output logic [FWD_WIDTH-1:0] w_res_data,
    output logic [ROW_W-1:0]     w_res_row,
    output logic                 w_res_last,
    output logic                 w_err
);

    localparam int D_W   = drain_cnt_width(ROWS);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int PAY_W = 1 + ROW_W + FWD_WIDTH;

    localparam logic [D_W-1:0]   SHIFT_LAST   = D_W'(2 * ROWS - 2);
    localparam logic [CNT_W-1:0] SNAP_MAX_OCC = CNT_W'(FIFO_DEPTH - ROWS);
    localparam logic [ROW_W-1:0] TOP_ROW      = ROW_W'(ROWS - 1);

    os_state_e        state;
    os_state_e        state_nxt;
    logic [K_WIDTH-1:0] k_rem;
    logic [D_W-1:0]   d_cnt;
    logic [2:0]       pe_ctl;

    logic             snap_go;
    logic             push;
    logic [ROW_W-1:0] push_row;
    logic             push_last;
    logic [PAY_W-1:0] push_data;
    logic [PAY_W-1:0] head_data;
    logic [CNT_W-1:0] fifo_count;

    // SNAP may only hand over to SHIFT when the whole tile is guaranteed a
    // slot; the decision uses registered occupancy, so a pop in the same
    // cycle only helps on the following cycle
    assign snap_go = (fifo_count <= SNAP_MAX_OCC);

    // State register plus the two counters: k_rem counts down MAC cycles and
    // d_cnt is the drain index (0 in SNAP, counting up through SHIFT/FINAL)
    always_ff @(posedge w_clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            state <= IDLE;
            k_rem <= '0;
            d_cnt <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (w_start) begin
                        k_rem <= w_k;
                    end
                    d_cnt <= '0;
                end
                MAC: begin
                    k_rem <= k_rem - 1'b1;
                end
                SNAP: begin
                    d_cnt <= snap_go ? D_W'(1) : '0;
                end
                SHIFT: begin
                    d_cnt <= d_cnt + 1'b1;
                end
                default: begin
                    d_cnt <= '0;
                end
            endcase
        end
    end

    // Next-state logic and the broadcast PE controls for each phase
    always_comb begin
        state_nxt = state;
        pe_ctl    = PE_CTL_CLEAR;
        case (state)
            IDLE: begin
                if (w_start) begin
                    state_nxt = LOAD;
                end
            end
            LOAD: begin
                state_nxt = (k_rem == '0) ? SNAP : MAC;
            end
            MAC: begin
                pe_ctl = PE_CTL_MAC;
                if (k_rem == K_WIDTH'(1)) begin
                    state_nxt = SNAP;
                end
            end
            SNAP: begin
                pe_ctl = PE_CTL_SNAP;
                if (snap_go) begin
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                pe_ctl = PE_CTL_SHIFT;
                if (d_cnt == SHIFT_LAST) begin
                    state_nxt = FINAL;
                end
            end
            FINAL: begin
                pe_ctl    = PE_CTL_FINAL;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign {w_pe_ready, w_pe_rw, w_pe_stream} = pe_ctl;
    assign w_busy        = (state != IDLE);
    assign w_done        = (state == FINAL);
    assign w_mac_en      = (state == MAC);
    assign w_pe_fwd_head = '0;

    // Odd drain indices carry real data: index 2j+1 holds row ROWS-1-j.
    // The last of those (row 0) lands in FINAL rather than SHIFT.
    assign push      = ((state == SHIFT) || (state == FINAL)) && d_cnt[0];
    assign push_row  = TOP_ROW - ROW_W'(d_cnt >> 1);
    assign push_last = (push_row == '0);
    assign push_data = {push_last, push_row, w_pe_tail};

    os_drain_fifo #(
        .WIDTH (PAY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .w_clk       (w_clk),
        .w_rst_n     (w_rst_n),
        .w_push      (push),
        .w_push_data (push_data),
        .w_pop       (w_res_ready),
        .w_valid     (w_res_valid),
        .w_pop_data  (head_data),
        .w_count     (fifo_count)
    );

    assign {w_res_last, w_res_row, w_res_data} = head_data;

`ifdef OS_DRAIN_BUBBLE_CHECK_EN
    logic err_q;
    logic bubble;
    logic fifo_full;

    assign bubble    = (state == SHIFT) && !d_cnt[0];
    assign fifo_full = (fifo_count == CNT_W'(FIFO_DEPTH));

    // Sticky error: a bubble slot must be exactly zero (unknown bits count as
    // a violation), and a push must never meet a full FIFO
    always_ff @(posedge w_clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            err_q <= 1'b0;
        end else if ((bubble && ((|w_pe_tail) !== 1'b0)) || (push && fifo_full)) begin
            err_q <= 1'b1;
        end
    end

    assign w_err = err_q;
`else
    assign w_err = 1'b0;
`endif

endmodule

// File: tb/tb_os_col_drain.sv
// -----------------------------------------------------------------------------
// tb_os_col_drain
// Self-checking bench for os_col_drain (ROWS=4, FWD_WIDTH=16, FIFO_DEPTH=8).
// A behavioural PE column (accumulators plus an interleaved drain line) feeds
// the tail; expected results are plain sums of the operands fed in each tile.
// -----------------------------------------------------------------------------
module tb_os_col_drain;

    localparam int ROWS       = 4;
    localparam int FWD_WIDTH  = 16;
    localparam int K_WIDTH    = 8;
    localparam int FIFO_DEPTH = 8;
    localparam int ROW_W      = 2;
    localparam int MAXK       = 32;

    logic                 w_clk = 1'b0;
    logic                 w_rst_n;
    logic                 w_start;
    logic [K_WIDTH-1:0]   w_k;
    logic                 w_busy;
    logic                 w_done;
    logic                 w_mac_en;
    logic                 w_pe_ready;
    logic                 w_pe_rw;
    logic                 w_pe_stream;
    logic [FWD_WIDTH-1:0] w_pe_fwd_head;
    logic [FWD_WIDTH-1:0] w_pe_tail;
    logic                 w_res_valid;
    logic                 w_res_ready;
    logic [FWD_WIDTH-1:0] w_res_data;
    logic [ROW_W-1:0]     w_res_row;
    logic                 w_res_last;
    logic                 w_err;

    always #5 w_clk = ~w_clk;

    os_col_drain #(
        .ROWS       (ROWS),
        .FWD_WIDTH  (FWD_WIDTH),
        .K_WIDTH    (K_WIDTH),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .w_clk         (w_clk),
        .w_rst_n       (w_rst_n),
        .w_start       (w_start),
        .w_k           (w_k),
        .w_busy        (w_busy),
        .w_done        (w_done),
        .w_mac_en      (w_mac_en),
        .w_pe_ready    (w_pe_ready),
        .w_pe_rw       (w_pe_rw),
        .w_pe_stream   (w_pe_stream),
        .w_pe_fwd_head (w_pe_fwd_head),
        .w_pe_tail     (w_pe_tail),
        .w_res_valid   (w_res_valid),
        .w_res_ready   (w_res_ready),
        .w_res_data    (w_res_data),
        .w_res_row     (w_res_row),
        .w_res_last    (w_res_last),
        .w_err         (w_err)
    );

    typedef struct packed {
        logic                 last;
        logic [ROW_W-1:0]     row;
        logic [FWD_WIDTH-1:0] data;
    } result_t;

    typedef struct {
        int k;
        int mode;
        int exp_done;
    } vec_t;

    int total = 0;
    int bad   = 0;
    int done_pulses = 0;
    int popped = 0;
    int ready_mode = 0;
    logic inject = 1'b0;

    result_t sbq [$];
    result_t exp_r;

    logic [FWD_WIDTH-1:0] plan    [MAXK][ROWS];
    logic [FWD_WIDTH-1:0] cur_op  [ROWS];
    logic [FWD_WIDTH-1:0] scratch [ROWS];
    logic [FWD_WIDTH-1:0] chain   [2*ROWS-1];

    // Tail of the modelled column, with an optional fault forced onto it
    assign w_pe_tail = chain[0] | (inject ? 16'h0040 : 16'h0000);

    // Behavioural PE column: accumulate during MAC, load an interleaved
    // {row ROWS-1, 0, row ROWS-2, 0, ... row 0} line on SNAP, shift on SHIFT
    always @(posedge w_clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            for (int r = 0; r < ROWS; r++) scratch[r] <= '0;
            for (int i = 0; i < 2*ROWS-1; i++) chain[i] <= '0;
        end else begin
            case ({w_pe_ready, w_pe_rw, w_pe_stream})
                3'b110: for (int r = 0; r < ROWS; r++) scratch[r] <= scratch[r] + cur_op[r];
                3'b100: begin
                    for (int j = 0; j < ROWS; j++) chain[2*j] <= scratch[ROWS-1-j];
                    for (int j = 0; j < ROWS-1; j++) chain[2*j+1] <= '0;
                end
                3'b111: begin
                    for (int i = 0; i < 2*ROWS-2; i++) chain[i] <= chain[i+1];
                    chain[2*ROWS-2] <= '0;
                end
                3'b000: begin
                    for (int r = 0; r < ROWS; r++) scratch[r] <= '0;
                    for (int i = 0; i < 2*ROWS-1; i++) chain[i] <= '0;
                end
                default: ;
            endcase
        end
    end

    // Consumer ready driver, applied a little after each rising edge
    always @(posedge w_clk) begin
        #2;
        case (ready_mode)
            0:       w_res_ready = 1'b0;
            1:       w_res_ready = 1'b1;
            default: w_res_ready = 1'($urandom_range(0, 1));
        endcase
    end

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    task automatic failNow(input string name);
        total++;
        bad++;
        $display("[TB] FAIL %s: got timeout expected completion", name);
    endtask

    // Scoreboard: every accepted result must be the oldest outstanding one
    always @(negedge w_clk) begin
        if (w_rst_n) begin
            if (w_done) done_pulses++;
            if (w_res_valid && w_res_ready) begin
                if (sbq.size() == 0) begin
                    failNow("unexpected_result");
                end else begin
                    exp_r = sbq.pop_front();
                    checkOutput("result", {w_res_last, w_res_row, w_res_data}, exp_r);
                    popped++;
                end
            end
        end
    end

    function automatic logic [5:0] expPhase(input int c, input int k);
        // {busy, done, mac_en, ready, rw, stream}
        if (c == 1)                 return 6'b100_000;
        else if (c <= k + 1)        return 6'b101_110;
        else if (c == k + 2)        return 6'b100_100;
        else if (c <= k + 2*ROWS)   return 6'b100_111;
        else if (c == k + 2*ROWS+1) return 6'b110_000;
        else                        return 6'b000_000;
    endfunction

    task automatic fillPlan(input int k, input int mode);
        for (int i = 0; i < MAXK; i++)
            for (int r = 0; r < ROWS; r++)
                plan[i][r] = (mode == 0) ? FWD_WIDTH'(2*(r+1)) : FWD_WIDTH'($urandom_range(0, 4095));
        if (k > MAXK) $display("[TB] k too large for plan table");
    endtask

    task automatic driveOps(input int c, input int k);
        for (int r = 0; r < ROWS; r++)
            cur_op[r] = (c >= 2 && c <= k + 1) ? plan[c-2][r] : '0;
    endtask

    task automatic checkResetState(input string tag);
        checkOutput({tag, "_ctl"}, {w_busy, w_done, w_mac_en, w_pe_ready, w_pe_rw, w_pe_stream,
                                    w_res_valid, w_res_last, w_err}, 9'd0);
        checkOutput({tag, "_data"}, {w_res_row, w_res_data, w_pe_fwd_head}, '0);
    endtask

    // Run one tile: start in an IDLE cycle, feed planned operands, optionally
    // check every cycle against the nominal schedule, stop at w_done
    task automatic applyStimulus(input int k, input bit timed, input int poke_c,
                                 input int inject_c, output int done_c);
        int guard;
        int first_v;
        bit track_v;
        logic [FWD_WIDTH-1:0] sum;
        guard = 0;
        @(posedge w_clk); #1;
        if (timed) begin
            while (sbq.size() > FIFO_DEPTH - ROWS && guard < 400) begin
                @(posedge w_clk); #1;
                guard++;
            end
            if (guard >= 400) failNow("room_wait");
        end
        track_v = (sbq.size() == 0);
        for (int j = 0; j < ROWS; j++) begin
            sum = '0;
            for (int i = 0; i < k; i++) sum = sum + plan[i][ROWS-1-j];
            sbq.push_back({(j == ROWS-1), ROW_W'(ROWS-1-j), sum});
        end
        w_start = 1'b1;
        w_k     = K_WIDTH'(k);
        done_c  = -1;
        first_v = -1;
        for (int c = 1; c <= k + 2*ROWS + (timed ? 8 : 1000); c++) begin
            @(posedge w_clk); #1;
            w_start = (c == poke_c);
            if (c == poke_c) w_k = 8'd9;
            inject = (c == inject_c);
            driveOps(c, k);
            if (first_v < 0 && w_res_valid) first_v = c;
            if (timed)
                checkOutput($sformatf("phase_k%0d_c%0d", k, c),
                            {w_busy, w_done, w_mac_en, w_pe_ready, w_pe_rw, w_pe_stream},
                            expPhase(c, k));
            if (w_done) begin
                done_c = c;
                break;
            end
        end
        inject  = 1'b0;
        w_start = 1'b0;
        driveOps(0, 0);
        if (done_c < 0) failNow("tile_done");
        if (timed && track_v) checkOutput("first_valid", first_v, k + 4);
    endtask

    task automatic waitDrain();
        int g;
        g = 0;
        ready_mode = 1;
        while (sbq.size() != 0 && g < 300) begin
            @(posedge w_clk); #1;
            g++;
        end
        checkOutput("drain_left", sbq.size(), 0);
        @(posedge w_clk); #1;
        checkOutput("fifo_empty", w_res_valid, 1'b0);
    endtask

    vec_t tbl [6];
    int dc;
    int dp0;
    int pop0;
    logic exp_err;

    initial begin
        w_rst_n = 1'b0;
        w_start = 1'b0;
        w_k     = '0;
        w_res_ready = 1'b0;
        driveOps(0, 0);
`ifdef OS_DRAIN_BUBBLE_CHECK_EN
        exp_err = 1'b1;
`else
        exp_err = 1'b0;
`endif
        tbl[0] = '{0,  0, 9};
        tbl[1] = '{1,  1, 10};
        tbl[2] = '{2,  1, 11};
        tbl[3] = '{5,  0, 14};
        tbl[4] = '{7,  1, 16};
        tbl[5] = '{20, 1, 29};

        repeat (3) @(posedge w_clk);
        #1;
        checkResetState("reset");
        w_rst_n = 1'b1;

        // Basic tile: scratch 6,12,18,24 for rows 0..3, held in the FIFO
        $display("[TB] basic tile");
        ready_mode = 0;
        fillPlan(3, 0);
        applyStimulus(3, 1, -1, -1, dc);
        checkOutput("basic_done_cycle", dc, 12);
        @(posedge w_clk); #1;
        checkOutput("basic_head", {w_res_last, w_res_row, w_res_data}, {1'b0, 2'd3, 16'd24});
        waitDrain();

        // Table of tiles run back to back under random consumer stalls
        $display("[TB] table tiles");
        ready_mode = 2;
        for (int t = 0; t < 6; t++) begin
            fillPlan(tbl[t].k, tbl[t].mode);
            applyStimulus(tbl[t].k, 1, -1, -1, dc);
            checkOutput($sformatf("tbl%0d_done_cycle", t), dc, tbl[t].exp_done);
        end
        waitDrain();

        // Backpressure: two tiles fill the FIFO, the third waits in SNAP
        $display("[TB] backpressure");
        ready_mode = 0;
        pop0 = popped;
        fillPlan(2, 1);
        applyStimulus(2, 1, -1, -1, dc);
        fillPlan(2, 1);
        applyStimulus(2, 1, -1, -1, dc);
        fork
            begin
                fillPlan(3, 1);
                applyStimulus(3, 0, -1, -1, dc);
            end
            begin
                repeat (10) @(posedge w_clk);
                #1;
                checkOutput("bp_stall_ctl", {w_busy, w_pe_ready, w_pe_rw, w_pe_stream}, 4'b1100);
                checkOutput("bp_no_done", w_done, 1'b0);
                ready_mode = 1;
                repeat (4) @(posedge w_clk);
                #1;
                ready_mode = 0;
            end
        join
        checkOutput("bp_popped_early", popped - pop0, 4);
        waitDrain();
        checkOutput("bp_total_results", popped - pop0, 12);

        // Reset during SHIFT discards everything and issues no done
        $display("[TB] reset mid-drain");
        ready_mode = 0;
        fillPlan(4, 0);
        @(posedge w_clk); #1;
        w_start = 1'b1;
        w_k     = 8'd4;
        for (int c = 1; c <= 8; c++) begin
            @(posedge w_clk); #1;
            w_start = 1'b0;
            driveOps(c, 4);
        end
        checkOutput("pre_reset_shift", {w_pe_ready, w_pe_rw, w_pe_stream}, 3'b111);
        dp0 = done_pulses;
        w_rst_n = 1'b0;
        driveOps(0, 0);
        #1;
        checkResetState("midreset");
        sbq.delete();
        @(posedge w_clk); #3;
        w_rst_n = 1'b1;
        repeat (12) @(posedge w_clk);
        #1;
        checkOutput("no_partial_done", done_pulses - dp0, 0);
        checkResetState("post_reset");
        ready_mode = 2;
        fillPlan(2, 1);
        applyStimulus(2, 1, -1, -1, dc);
        checkOutput("after_reset_done", dc, 11);
        waitDrain();

        // A start pulse during MAC must be ignored
        $display("[TB] start while busy");
        dp0 = done_pulses;
        fillPlan(5, 1);
        applyStimulus(5, 1, 3, -1, dc);
        repeat (15) @(posedge w_clk);
        #1;
        checkOutput("single_done", done_pulses - dp0, 1);
        checkOutput("idle_after_ignored_start", w_busy, 1'b0);
        waitDrain();

        // Randomized tiles against the sum model
        $display("[TB] random tiles");
        ready_mode = 2;
        for (int n = 0; n < 25; n++) begin
            int k;
            k = $urandom_range(0, 12);
            fillPlan(k, 1);
            applyStimulus(k, 1, -1, -1, dc);
            checkOutput($sformatf("rand%0d_done_cycle", n), dc, k + 2*ROWS + 1);
        end
        waitDrain();

        // Bubble fault: tail forced nonzero at drain index 2
        $display("[TB] bubble checker");
        checkOutput("err_before_fault", w_err, 1'b0);
        fillPlan(1, 1);
        applyStimulus(1, 1, -1, 5, dc);
        @(posedge w_clk); #1;
        checkOutput("err_after_fault", w_err, exp_err);
        repeat (5) @(posedge w_clk);
        #1;
        checkOutput("err_sticky", w_err, exp_err);
        waitDrain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
